// File: rtl/noise_ctrl.sv
// rtl/noise_ctrl.sv - APU noise channel sequencer: NR41-NR44 registers, polynomial timer,
// length counter, volume envelope and sample gating in front of the noise LFSR.
module noise_ctrl #(
   parameter int TIMER_W = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       slow_clk_en,
   input  logic       cpu_en,
   input  logic [1:0] reg_sel,
   input  logic       reg_write,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   input  logic       length_tick,
   input  logic       env_tick,
   input  logic       lfsr_play,
   output logic       lfsr_init,
   output logic       lfsr_next_step,
   output logic       lfsr_width_write,
   output logic       lfsr_new_width,
   output logic       enabled,
   output logic [3:0] volume,
   output logic [3:0] sample
);

   localparam logic [TIMER_W-1:0] L_TIMER_ONE = TIMER_W'(1);

   logic [6:0]         r_len_cnt;
   logic               r_len_en;
   logic [3:0]         r_env_init;
   logic               r_env_dir;
   logic [2:0]         r_env_per;
   logic [2:0]         r_env_cnt;
   logic [3:0]         r_shift_s;
   logic               r_width;
   logic [2:0]         r_div_r;
   logic               r_enabled;
   logic [3:0]         r_volume;
   logic [3:0]         r_sample;
   logic [TIMER_W-1:0] r_timer;

   logic               w_wr;
   logic               w_wr41;
   logic               w_wr42;
   logic               w_wr43;
   logic               w_wr44;
   logic               w_trigger;
   logic               w_dac_on;
   logic [6:0]         w_base;
   logic [TIMER_W-1:0] w_period;
   logic               w_timer_run;
   logic               w_len_dec;
   logic               w_len_expire;
   logic               w_env_step;

   assign w_wr      = cpu_en & reg_write;
   assign w_wr41    = w_wr & (reg_sel == 2'd0);
   assign w_wr42    = w_wr & (reg_sel == 2'd1);
   assign w_wr43    = w_wr & (reg_sel == 2'd2);
   assign w_wr44    = w_wr & (reg_sel == 2'd3);
   assign w_trigger = w_wr44 & wdata[7];
   assign w_dac_on  = |{r_env_init, r_env_dir};

   assign w_base      = (r_div_r == 3'd0) ? 7'd8 : {r_div_r, 4'b0000};
   assign w_period    = TIMER_W'(w_base) << r_shift_s;
   assign w_timer_run = r_enabled & (r_shift_s < 4'd14);

   // A trigger or an NR41 write in the same clk swallows the length tick.
   assign w_len_dec    = length_tick & r_len_en & (r_len_cnt != 7'd0) & ~w_wr41 & ~w_trigger;
   assign w_len_expire = w_len_dec & (r_len_cnt == 7'd1);
   assign w_env_step   = env_tick & r_enabled & (r_env_per != 3'd0) & ~w_trigger;

   assign lfsr_init        = w_trigger;
   assign lfsr_width_write = w_wr43;
   assign lfsr_new_width   = wdata[3];
   assign lfsr_next_step   = ~reset & w_timer_run & (r_timer == L_TIMER_ONE);
   assign enabled          = r_enabled;
   assign volume           = r_volume;
   assign sample           = r_sample;

   always_comb begin
      rdata = 8'hFF;
      case (reg_sel)
         2'd0:    rdata = 8'hFF;
         2'd1:    rdata = {r_env_init, r_env_dir, r_env_per};
         2'd2:    rdata = {r_shift_s, r_width, r_div_r};
         default: rdata = {1'b1, r_len_en, 6'h3F};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_len_cnt  <= '0;
         r_len_en   <= 1'b0;
         r_env_init <= '0;
         r_env_dir  <= 1'b0;
         r_env_per  <= '0;
         r_env_cnt  <= '0;
         r_shift_s  <= '0;
         r_width    <= 1'b0;
         r_div_r    <= '0;
         r_enabled  <= 1'b0;
         r_volume   <= '0;
         r_sample   <= '0;
         r_timer    <= '0;
      end else begin
         r_sample <= (r_enabled & lfsr_play) ? r_volume : 4'd0;

         if (w_wr42) begin
            r_env_init <= wdata[7:4];
            r_env_dir  <= wdata[3];
            r_env_per  <= wdata[2:0];
         end
         if (w_wr43) begin
            r_shift_s <= wdata[7:4];
            r_width   <= wdata[3];
            r_div_r   <= wdata[2:0];
         end
         if (w_wr44) begin
            r_len_en <= wdata[6];
         end

         if (w_wr41) begin
            r_len_cnt <= 7'd64 - {1'b0, wdata[5:0]};
         end else if (w_trigger) begin
            if (r_len_cnt == 7'd0) begin
               r_len_cnt <= 7'd64;
            end
         end else if (w_len_dec) begin
            r_len_cnt <= r_len_cnt - 7'd1;
         end

         if (w_trigger) begin
            r_volume  <= r_env_init;
            r_env_cnt <= r_env_per;
         end else if (w_env_step) begin
            if (r_env_cnt > 3'd1) begin
               r_env_cnt <= r_env_cnt - 3'd1;
            end else begin
               r_env_cnt <= r_env_per;
               if (r_env_dir && (r_volume != 4'd15)) begin
                  r_volume <= r_volume + 4'd1;
               end else if (!r_env_dir && (r_volume != 4'd0)) begin
                  r_volume <= r_volume - 4'd1;
               end
            end
         end

         // Reload happens on the tick that sees timer==1, so next_step is high for one period slot.
         if (w_trigger) begin
            r_timer <= w_period;
         end else if (slow_clk_en && w_timer_run) begin
            r_timer <= (r_timer <= L_TIMER_ONE) ? w_period : r_timer - L_TIMER_ONE;
         end

         if (w_trigger) begin
            r_enabled <= w_dac_on;
         end else if ((w_wr42 && (wdata[7:3] == 5'd0)) || w_len_expire) begin
            r_enabled <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_noise_ctrl.sv
// tb/tb_noise_ctrl.sv - directed and randomized bench for noise_ctrl with a behavioural channel model.
module tb_noise_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       slow_clk_en;
   logic       cpu_en;
   logic [1:0] reg_sel;
   logic       reg_write;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       length_tick;
   logic       env_tick;
   logic       lfsr_play;
   logic       lfsr_init;
   logic       lfsr_next_step;
   logic       lfsr_width_write;
   logic       lfsr_new_width;
   logic       enabled;
   logic [3:0] volume;
   logic [3:0] sample;

   always #5 clk = ~clk;

   noise_ctrl #(.TIMER_W(20)) dut (
      .clk(clk), .reset(reset), .slow_clk_en(slow_clk_en), .cpu_en(cpu_en),
      .reg_sel(reg_sel), .reg_write(reg_write), .wdata(wdata), .rdata(rdata),
      .length_tick(length_tick), .env_tick(env_tick), .lfsr_play(lfsr_play),
      .lfsr_init(lfsr_init), .lfsr_next_step(lfsr_next_step),
      .lfsr_width_write(lfsr_width_write), .lfsr_new_width(lfsr_new_width),
      .enabled(enabled), .volume(volume), .sample(sample)
   );

   int checks = 0;
   int failures = 0;
   int step_seen = 0;

   int m_len, m_len_en, m_env_init, m_env_dir, m_env_per, m_env_cnt;
   int m_shift, m_width, m_div, m_en, m_vol, m_sample, m_timer;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int period_f();
      int b;
      b = (m_div == 0) ? 8 : 16 * m_div;
      return (b << m_shift) & 32'hFFFFF;
   endfunction

   function automatic int rd_exp(input int sel);
      case (sel)
         0:       return 255;
         1:       return m_env_init * 16 + m_env_dir * 8 + m_env_per;
         2:       return m_shift * 16 + m_width * 8 + m_div;
         default: return 128 + m_len_en * 64 + 63;
      endcase
   endfunction

   // One clk: check combinational outputs, advance the model, check registered outputs.
   task automatic cyc();
      int wr, trig, per, dac, expire, nsamp;
      #3;
      wr   = cpu_en & reg_write;
      trig = (wr != 0) && (reg_sel == 2'd3) && wdata[7];
      chk("next_step", lfsr_next_step, (!reset && m_en != 0 && m_shift < 14 && m_timer == 1));
      chk("lfsr_init", lfsr_init, trig);
      chk("width_write", lfsr_width_write, (wr != 0) && (reg_sel == 2'd2));
      if ((wr != 0) && (reg_sel == 2'd2)) chk("new_width", lfsr_new_width, wdata[3]);
      chk("rdata", rdata, rd_exp(reg_sel));
      step_seen = lfsr_next_step;

      if (reset) begin
         m_len = 0; m_len_en = 0; m_env_init = 0; m_env_dir = 0; m_env_per = 0; m_env_cnt = 0;
         m_shift = 0; m_width = 0; m_div = 0; m_en = 0; m_vol = 0; m_sample = 0; m_timer = 0;
      end else begin
         per    = period_f();
         dac    = (m_env_init != 0 || m_env_dir != 0);
         nsamp  = (m_en != 0 && lfsr_play) ? m_vol : 0;
         expire = 0;
         if (trig) m_timer = per;
         else if (slow_clk_en && m_en != 0 && m_shift < 14) m_timer = (m_timer <= 1) ? per : m_timer - 1;

         if (wr != 0 && reg_sel == 2'd0) m_len = 64 - int'(wdata[5:0]);
         else if (trig) begin
            if (m_len == 0) m_len = 64;
         end else if (length_tick && m_len_en != 0 && m_len != 0) begin
            m_len--;
            expire = (m_len == 0);
         end

         if (trig) begin
            m_vol = m_env_init;
            m_env_cnt = m_env_per;
         end else if (env_tick && m_en != 0 && m_env_per != 0) begin
            if (m_env_cnt > 1) m_env_cnt--;
            else begin
               m_env_cnt = m_env_per;
               if (m_env_dir != 0) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
               else m_vol = (m_vol > 0) ? m_vol - 1 : 0;
            end
         end

         if (trig) m_en = dac;
         else if ((wr != 0 && reg_sel == 2'd1 && wdata[7:3] == 5'd0) || expire != 0) m_en = 0;

         if (wr != 0 && reg_sel == 2'd1) begin
            m_env_init = wdata[7:4]; m_env_dir = wdata[3]; m_env_per = wdata[2:0];
         end
         if (wr != 0 && reg_sel == 2'd2) begin
            m_shift = wdata[7:4]; m_width = wdata[3]; m_div = wdata[2:0];
         end
         if (wr != 0 && reg_sel == 2'd3) m_len_en = wdata[6];
         m_sample = nsamp;
      end

      @(posedge clk);
      #1;
      chk("enabled", enabled, m_en);
      chk("volume", volume, m_vol);
      chk("sample", sample, m_sample);
      reg_write = 1'b0;
      length_tick = 1'b0;
      env_tick = 1'b0;
   endtask

   task automatic wr_reg(input logic [1:0] sel, input logic [7:0] data);
      cpu_en = 1'b1;
      reg_sel = sel;
      wdata = data;
      reg_write = 1'b1;
      cyc();
   endtask

   initial begin
      int cnt;
      int last;
      reset = 1'b1; slow_clk_en = 1'b0; cpu_en = 1'b0; reg_sel = 2'd0; reg_write = 1'b0;
      wdata = 8'h00; length_tick = 1'b0; env_tick = 1'b0; lfsr_play = 1'b0;
      cyc();
      cyc();
      chk("rst_enabled", enabled, 0);
      chk("rst_volume", volume, 0);
      chk("rst_nr41", rdata, 8'hFF);
      reset = 1'b0;
      slow_clk_en = 1'b1;
      lfsr_play = 1'b1;

      // Shortest period: one step per 8 ticks.
      wr_reg(2'd2, 8'h00);
      wr_reg(2'd1, 8'hF0);
      wr_reg(2'd3, 8'h80);
      chk("t1_enabled", enabled, 1);
      chk("t1_volume", volume, 15);
      cnt = 0;
      repeat (40) begin cyc(); cnt += step_seen; end
      chk("t1_steps", cnt, 5);

      wr_reg(2'd2, 8'h23);
      wr_reg(2'd3, 8'h80);
      cnt = 0; last = -1;
      for (int i = 1; i <= 384; i++) begin
         cyc();
         if (step_seen != 0) begin
            if (last >= 0) chk("t2_interval", i - last, 192);
            last = i;
            cnt++;
         end
      end
      chk("t2_steps", cnt, 2);

      wr_reg(2'd2, 8'hE0);
      wr_reg(2'd3, 8'h80);
      cnt = 0;
      repeat (3000) begin cyc(); cnt += step_seen; end
      chk("t3_frozen_steps", cnt, 0);

      // Length expiry after two ticks.
      wr_reg(2'd0, 8'h3E);
      wr_reg(2'd3, 8'hC0);
      chk("t4_en_start", enabled, 1);
      length_tick = 1'b1; cyc();
      chk("t4_en_tick1", enabled, 1);
      length_tick = 1'b1; cyc();
      chk("t4_en_tick2", enabled, 0);
      cyc(); cyc();
      chk("t4_sample_off", sample, 0);

      // Envelope ramps up one step every two env ticks.
      wr_reg(2'd1, 8'h0A);
      wr_reg(2'd3, 8'h80);
      chk("t5_vol0", volume, 0);
      for (int i = 1; i <= 40; i++) begin
         env_tick = 1'b1;
         cyc();
         if (i == 4) chk("t5_vol_4", volume, 2);
         if (i == 29) chk("t5_vol_29", volume, 14);
      end
      chk("t5_vol_sat", volume, 15);

      wr_reg(2'd1, 8'h00);
      wr_reg(2'd3, 8'h80);
      chk("t6_dac_off_trig", enabled, 0);
      wr_reg(2'd1, 8'hF0);
      wr_reg(2'd3, 8'h80);
      chk("t6_dac_on_trig", enabled, 1);
      wr_reg(2'd1, 8'h07);
      chk("t6_dac_off_write", enabled, 0);

      // Trigger at len_cnt==0 with a coincident length tick reloads 64 untouched.
      wr_reg(2'd1, 8'hF0);
      wr_reg(2'd0, 8'h3F);
      wr_reg(2'd3, 8'hC0);
      length_tick = 1'b1; cyc();
      chk("t7_len_zero", enabled, 0);
      length_tick = 1'b1;
      wr_reg(2'd3, 8'hC0);
      chk("t7_retrig", enabled, 1);
      repeat (63) begin length_tick = 1'b1; cyc(); end
      chk("t7_after63", enabled, 1);
      length_tick = 1'b1; cyc();
      chk("t7_after64", enabled, 0);

      // Reset lands exactly where a step would otherwise be issued.
      wr_reg(2'd2, 8'h00);
      wr_reg(2'd3, 8'h80);
      repeat (7) cyc();
      reset = 1'b1; length_tick = 1'b1; env_tick = 1'b1;
      cyc();
      reg_sel = 2'd3;
      #1;
      chk("rst_mid_nr44", rdata, 8'hBF);
      chk("rst_mid_step", lfsr_next_step, 0);
      chk("rst_mid_en", enabled, 0);
      chk("rst_mid_vol", volume, 0);
      reset = 1'b0;

      for (int i = 0; i < 2500; i++) begin
         reset       = ($urandom_range(0, 499) == 0);
         slow_clk_en = ($urandom_range(0, 3) != 0);
         cpu_en      = ($urandom_range(0, 3) != 0);
         reg_write   = ($urandom_range(0, 5) == 0);
         reg_sel     = 2'($urandom_range(0, 3));
         wdata       = 8'($urandom);
         if (reg_sel == 2'd2 && $urandom_range(0, 3) != 0) wdata[7:4] = 4'($urandom_range(0, 2));
         length_tick = ($urandom_range(0, 7) == 0);
         env_tick    = ($urandom_range(0, 7) == 0);
         lfsr_play   = 1'($urandom);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
